// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its button front end.
package stopwatch_pkg;

  localparam int DIGIT_W  = 4;
  localparam int N_DIGITS = 4;
  localparam logic [N_DIGITS*DIGIT_W-1:0] BCD_MAX = 16'h9999;

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLEAR = 2;
  localparam int N_BTN     = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LAP,
    S_FULL
  } state_t;

  // Overflow beats every button; among buttons clear > start > lap.
  function automatic state_t next_state(input state_t cur, input logic ovf,
                                        input logic clr, input logic start,
                                        input logic lap);
    state_t nxt;
    nxt = cur;
    case (cur)
      S_IDLE:  if (clr) nxt = S_IDLE; else if (start) nxt = S_RUN;
      S_RUN:   if (ovf) nxt = S_FULL; else if (start) nxt = S_PAUSE; else if (lap) nxt = S_LAP;
      S_LAP:   if (ovf) nxt = S_FULL; else if (start) nxt = S_PAUSE; else if (lap) nxt = S_RUN;
      S_PAUSE: if (clr) nxt = S_IDLE; else if (start) nxt = S_RUN;
      S_FULL:  if (clr) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Buttons, digit-chain feedback and control/display outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic                          btn_start;
  logic                          btn_lap;
  logic                          btn_clear;
  logic [N_DIGITS*DIGIT_W-1:0]   digits_in;
  logic                          count_en;
  logic                          count_clr;
  logic [N_DIGITS*DIGIT_W-1:0]   disp_digits;
  logic                          running;
  logic                          lap_active;
  logic                          overflow;

  modport master (
    input  btn_start, btn_lap, btn_clear, digits_in,
    output count_en, count_clr, disp_digits, running, lap_active, overflow
  );

  modport slave (
    output btn_start, btn_lap, btn_clear, digits_in,
    input  count_en, count_clr, disp_digits, running, lap_active, overflow
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge event pulse for one button.
module btn_debounce #(
  parameter int DB_N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam logic [DB_N-1:0] CNT_MAX = '1;

  logic            sync1_reg;
  logic            sync2_reg;
  logic            level_reg;
  logic            armed_reg;
  logic [DB_N-1:0] cnt_reg;

  // Until a full stable-low window has been seen after reset the button is
  // treated as held through reset, so it cannot produce an event yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      armed_reg <= 1'b0;
      cnt_reg   <= '0;
      pulse     <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      pulse     <= 1'b0;
      if (!armed_reg) begin
        if (sync2_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          armed_reg <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_MAX) begin
          level_reg <= sync2_reg;
          pulse     <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons drive run/pause/lap/clear, with overflow at 99.99.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_N = 20
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.master  bus
);

  logic [N_BTN-1:0]              btn_raw;
  logic [N_BTN-1:0]              btn_ev;
  state_t                        state_reg;
  state_t                        state_next;
  logic [N_DIGITS*DIGIT_W-1:0]   lap_reg;
  logic                          ovf_hit;
  logic                          clr_accept;

  assign btn_raw[BTN_START] = bus.btn_start;
  assign btn_raw[BTN_LAP]   = bus.btn_lap;
  assign btn_raw[BTN_CLEAR] = bus.btn_clear;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(.DB_N(DB_N)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[gi]),
        .pulse (btn_ev[gi])
      );
    end
  endgenerate

  assign ovf_hit    = (state_reg == S_RUN || state_reg == S_LAP) && (bus.digits_in == BCD_MAX);
  assign clr_accept = btn_ev[BTN_CLEAR] &&
                      (state_reg == S_IDLE || state_reg == S_PAUSE || state_reg == S_FULL);
  assign state_next = next_state(state_reg, ovf_hit, btn_ev[BTN_CLEAR],
                                 btn_ev[BTN_START], btn_ev[BTN_LAP]);

  // Outputs are decoded from the state being entered so they settle with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      lap_reg         <= '0;
      bus.count_en    <= 1'b0;
      bus.count_clr   <= 1'b0;
      bus.running     <= 1'b0;
      bus.lap_active  <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.disp_digits <= '0;
    end else begin
      state_reg       <= state_next;
      bus.count_en    <= (state_next == S_RUN) || (state_next == S_LAP);
      bus.running     <= (state_next == S_RUN) || (state_next == S_LAP);
      bus.lap_active  <= (state_next == S_LAP);
      bus.overflow    <= (state_next == S_FULL);
      bus.count_clr   <= clr_accept;
      if (state_reg == S_RUN && state_next == S_LAP)
        lap_reg <= bus.digits_in;
      bus.disp_digits <= (state_reg == S_LAP && state_next == S_LAP) ? lap_reg : bus.digits_in;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: every change of the output bundle is matched against a queued expectation.
module tb_stopwatch_ctrl;

  localparam int DB_N = 4;
  localparam int LAT  = 3 + (1 << DB_N);  // raw press edge to registered FSM outputs

  typedef struct {
    logic [20:0] val;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   have_prev;
  logic [20:0] prev;
  exp_t sb[$];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.DB_N(DB_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [20:0] bundle(input bit en, input bit clr, input bit run,
                                         input bit lap, input bit ovf, input logic [15:0] d);
    return {en, clr, run, lap, ovf, d};
  endfunction

  task automatic expect_at(input logic [20:0] v, input int offset);
    exp_t e;
    e.val = v;
    e.due = (offset == 0) ? 0 : cyc + offset;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the selected buttons for hold cycles, then release and let the release debounce.
  task automatic press(input bit s, input bit l, input bit c, input int hold);
    sw_if.btn_start = s;
    sw_if.btn_lap   = l;
    sw_if.btn_clear = c;
    step(hold);
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    sw_if.btn_clear = 1'b0;
    step(22);
  endtask

  // Monitor: sample opposite the active edge; any bundle change must match the queue head.
  always @(negedge clk) begin
    logic [20:0] cur;
    exp_t e;
    cur = {sw_if.count_en, sw_if.count_clr, sw_if.running, sw_if.lap_active,
           sw_if.overflow, sw_if.disp_digits};
    if (!have_prev || cur != prev) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, cur);
      end else begin
        e = sb.pop_front();
        if (cur != e.val || (e.due != 0 && e.due != cyc)) begin
          n_err++;
          $display("FAIL out_bundle cyc=%0d got=%h expected=%h due_cyc=%0d", cyc, cur, e.val, e.due);
        end else begin
          $display("vec %0d cyc=%0d en/clr/run/lap/ovf/disp=%h ok", n_vec, cyc, cur);
        end
      end
    end
    prev      = cur;
    have_prev = 1'b1;
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    have_prev = 1'b0;
    prev = '0;
    reset = 1'b1;
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    sw_if.btn_clear = 1'b0;
    sw_if.digits_in = 16'h0000;
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0000), 0);
    step(3);
    reset = 1'b0;
    step(25);

    // Display follows the digit chain while idle.
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0123), 1);
    sw_if.digits_in = 16'h0123;
    step(5);

    // Bouncing start: three short glitches, then a clean hold -> one event, RUN.
    for (int i = 0; i < 3; i++) begin
      sw_if.btn_start = 1'b1;
      step(5);
      sw_if.btn_start = 1'b0;
      step(5);
    end
    expect_at(bundle(1, 0, 1, 0, 0, 16'h0123), LAT);
    press(1, 0, 0, 20);

    // Lap freezes display at 0123 while the chain moves on to 0456.
    expect_at(bundle(1, 0, 1, 1, 0, 16'h0123), LAT);
    press(0, 1, 0, 20);
    sw_if.digits_in = 16'h0456;
    step(10);
    expect_at(bundle(1, 0, 1, 0, 0, 16'h0456), LAT);
    press(0, 1, 0, 20);

    // RUN -> PAUSE -> clear pulse -> IDLE.
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0456), LAT);
    press(1, 0, 0, 20);
    expect_at(bundle(0, 1, 0, 0, 0, 16'h0456), LAT);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0456), LAT + 1);
    press(0, 0, 1, 20);

    // Overflow at 9999 from RUN; start and lap ignored in FULL; clear returns to IDLE.
    expect_at(bundle(1, 0, 1, 0, 0, 16'h0456), LAT);
    press(1, 0, 0, 20);
    expect_at(bundle(0, 0, 0, 0, 1, 16'h9999), 1);
    sw_if.digits_in = 16'h9999;
    step(5);
    press(1, 0, 0, 20);
    press(0, 1, 0, 20);
    expect_at(bundle(0, 1, 0, 0, 0, 16'h9999), LAT);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h9999), LAT + 1);
    press(0, 0, 1, 20);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0000), 1);
    sw_if.digits_in = 16'h0000;
    step(5);

    // IDLE: lap ignored, clear still pulses.
    press(0, 1, 0, 20);
    expect_at(bundle(0, 1, 0, 0, 0, 16'h0000), LAT);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0000), LAT + 1);
    press(0, 0, 1, 20);

    // PAUSE with clear and start together: clear wins, count_en stays low.
    expect_at(bundle(1, 0, 1, 0, 0, 16'h0000), LAT);
    press(1, 0, 0, 20);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0000), LAT);
    press(1, 0, 0, 20);
    expect_at(bundle(0, 1, 0, 0, 0, 16'h0000), LAT);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0000), LAT + 1);
    press(1, 0, 1, 20);

    // Into LAP, then reset mid-operation with start held through the reset release.
    expect_at(bundle(1, 0, 1, 0, 0, 16'h0000), LAT);
    press(1, 0, 0, 20);
    expect_at(bundle(1, 0, 1, 1, 0, 16'h0000), LAT);
    press(0, 1, 0, 20);
    sw_if.digits_in = 16'h0777;
    step(5);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0000), 1);
    reset = 1'b1;
    sw_if.btn_start = 1'b1;
    step(3);
    expect_at(bundle(0, 0, 0, 0, 0, 16'h0777), 1);
    reset = 1'b0;
    step(30);
    sw_if.btn_start = 1'b0;
    step(22);
    expect_at(bundle(1, 0, 1, 0, 0, 16'h0777), LAT);
    press(1, 0, 0, 20);

    step(5);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_change expected=%h due_cyc=%0d got no change", e.val, e.due);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_N, default 20, width of the debounce stability counter; a button level is accepted after 2^DB_N stable cycles.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_start  input  1  raw start/stop push button, asynchronous to clk.
REQ-005 btn_lap  input  1  raw lap push button, asynchronous to clk.
REQ-006 btn_clear  input  1  raw clear push button, asynchronous to clk.
REQ-007 digits_in  input  16  live BCD count from the digit chain, 4 digits, [3:0] = least significant.
REQ-008 count_en  output  1  run enable to the centisecond timebase and digit chain.
REQ-009 count_clr  output  1  one-cycle soft clear to the timebase and all digit counters.
REQ-010 disp_digits  output  16  BCD digits routed to the display path.
REQ-011 running  output  1  high in RUN and LAP.
REQ-012 lap_active  output  1  high while the display is frozen (LAP).
REQ-013 overflow  output  1  high in FULL.

Function
REQ-014 Each button passes through a 2-flop synchroniser, then the debouncer; one 1-cycle event pulse is generated per accepted rising edge only.
REQ-015 Debounced level changes only after 2^DB_N consecutive cycles at the new synchronised value; any glitch restarts the count.
REQ-016 FSM states: IDLE, RUN, PAUSE, LAP, FULL.
REQ-017 IDLE: start -> RUN; clear -> IDLE with count_clr pulse; lap ignored.
REQ-018 RUN: start -> PAUSE; lap -> LAP, latching digits_in into the lap register that cycle; clear ignored.
REQ-019 LAP: lap -> RUN (display live again); start -> PAUSE (freeze released); clear ignored.
REQ-020 PAUSE: start -> RUN; clear -> IDLE with count_clr pulse; lap ignored.
REQ-021 FULL: clear -> IDLE with count_clr pulse; start and lap ignored.
REQ-022 In RUN or LAP, digits_in == 16'h9999 -> FULL; freeze released; this overrides any button event that cycle.
REQ-023 Simultaneous events priority: overflow > clear > start > lap; at most one transition per cycle.
REQ-024 count_en, count_clr, running, lap_active, overflow are registered, reflecting the new state one cycle after the event.
REQ-025 count_en = 1 exactly in RUN and LAP.
REQ-026 count_clr is high for exactly one cycle per accepted clear, and never while count_en is high.
REQ-027 disp_digits is registered: lap register in LAP, otherwise digits_in, with 1-cycle latency.
REQ-028 Event pulses arriving during the cycle of a transition are evaluated against the pre-transition state only.

Reset
REQ-029 On reset: state IDLE; count_en 0, count_clr 0, running 0, lap_active 0, overflow 0.
REQ-030 On reset: disp_digits 16'h0000, lap register 0, synchronisers and debounced levels 0, debounce counters 0.
REQ-031 Reset mid-operation, in any state, takes effect on the next edge and discards pending button events.
REQ-032 A button held through reset release produces no event until it is released and pressed again.

Structure
REQ-033 Shared package stopwatch_pkg holds the state encoding, BCD_MAX = 16'h9999, and the digit-field width 4.
REQ-034 One sub-module, btn_debounce (synchroniser, stability counter, rising-edge pulse), is instantiated three times.

Verification (DB_N = 4)
REQ-035 Reset, press start 20 cycles -> after debounce, count_en = 1 and running = 1 one cycle after the pulse.
REQ-036 Start bouncing 3 times (5-cycle pulses), then held 20 cycles -> exactly one event; state RUN.
REQ-037 RUN with digits_in = 16'h0123, press lap, then drive digits_in = 16'h0456 -> disp_digits stays 16'h0123 and lap_active = 1; press lap again -> disp_digits = 16'h0456 next cycle.
REQ-038 RUN, press start, then clear -> PAUSE, count_en = 0, then one count_clr pulse; state IDLE.
REQ-039 RUN, digits_in = 16'h9999 -> overflow = 1 and count_en = 0 next cycle; start ignored; clear -> IDLE with count_clr pulse.
REQ-040 Clear and start events in the same cycle in PAUSE -> IDLE with count_clr pulse, count_en stays 0; reset asserted in LAP -> all outputs 0 next cycle.
